// File: rtl/light_sched_pkg.sv
// Shared types and constants for the hazard-light mode scheduler.
package light_sched_pkg;

    localparam int NUM_REQ = 2;

    // Mode codes understood by the downstream pattern FSM.
    typedef enum logic [1:0] {
        CALM   = 2'b00,
        R2L    = 2'b01,
        L2R    = 2'b10,
        FREEZE = 2'b11
    } light_mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        PEND  = 2'b01,
        DWELL = 2'b10
    } sched_state_t;

endpackage

// File: rtl/step_prescaler.sv
// Free-running prescaler that emits a one-cycle step strobe every 2**DIV_W
// clocks. The strobe is registered and is high exactly in the cycle the
// counter holds all-ones.
module step_prescaler #(
    parameter int DIV_W = 24
) (
    input  logic clock,
    input  logic reset,
    output logic step
);

    localparam logic [DIV_W-1:0] ALL_ONES = '1;
    localparam logic [DIV_W-1:0] PRE_LAST = ALL_ONES - DIV_W'(1);

    logic [DIV_W-1:0] r_count;
    logic             r_step;

    // Count up and wrap; raise the strobe one cycle ahead so it lines up with all-ones.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
            r_step  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            r_count <= r_count + DIV_W'(1);
            r_step  <= (r_count == PRE_LAST);
        end
    end

    assign step = r_step;

endmodule

// File: rtl/light_mode_scheduler.sv
// Arbitrates two mode requesters (0 = tower panel, 1 = wind sensor) and
// applies the granted mode on a step boundary, then holds it for MIN_DWELL
// steps before accepting another request.
// Build option: define LMS_ROUND_ROBIN_EN for round-robin tie-breaking;
// otherwise the tower panel wins every tie.
module light_mode_scheduler
    import light_sched_pkg::*;
#(
    parameter int DIV_W     = 24,
    parameter int MIN_DWELL = 8,
    parameter int DWELL_W   = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic [1:0] req_mode0,
    input  logic [1:0] req_mode1,
    output logic [1:0] ack,
    output logic [1:0] mode,
    output logic       step,
    output logic       busy,
    output logic       owner
);

    logic                w_step;
    logic                w_winner;
    sched_state_t        r_state;
    sched_state_t        w_state_next;
    logic                r_winner;
    logic                w_winner_next;
    light_mode_t         r_lmode;
    light_mode_t         w_lmode_next;
    light_mode_t         r_mode;
    light_mode_t         w_mode_next;
    logic [NUM_REQ-1:0]  r_ack;
    logic [NUM_REQ-1:0]  w_ack_next;
    logic                r_owner;
    logic                w_owner_next;
    logic                r_busy;
    logic                w_busy_next;
    logic [DWELL_W-1:0]  r_dwell;
    logic [DWELL_W-1:0]  w_dwell_next;

    step_prescaler #(.DIV_W(DIV_W)) u_prescaler (
        .clock (clock),
        .reset (reset),
        .step  (w_step)
    );

    // Arbiter: a lone requester always wins; ties resolved by the build option.
    always_comb begin
        // NOTE: every comb output gets a default first so no latch is inferred.
        w_winner = 1'b0;
        if (req == 2'b10) begin
            w_winner = 1'b1;
        end else if (req == 2'b11) begin
`ifdef LMS_ROUND_ROBIN_EN
            w_winner = ~r_owner;
`else
            w_winner = 1'b0;
`endif
        end
    end

    // State register plus all registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_winner <= 1'b0;
            r_lmode  <= CALM;
            r_mode   <= CALM;
            r_ack    <= '0;
            r_owner  <= 1'b0;
            r_busy   <= 1'b0;
            r_dwell  <= '0;
        end else begin
            r_state  <= w_state_next;
            r_winner <= w_winner_next;
            r_lmode  <= w_lmode_next;
            r_mode   <= w_mode_next;
            r_ack    <= w_ack_next;
            r_owner  <= w_owner_next;
            r_busy   <= w_busy_next;
            r_dwell  <= w_dwell_next;
        end
    end

    // Next-state logic: a request only reaches the mode on a later step, and
    // DWELL releases on the step where the last dwell step is consumed.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (|req) w_state_next = PEND;
            PEND: begin
                if (!req[r_winner])  w_state_next = IDLE;
                else if (w_step)     w_state_next = DWELL;
            end
            DWELL:   if (w_step && (r_dwell == DWELL_W'(1))) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Output logic: next values for the registered outputs and latched request.
    always_comb begin
        w_winner_next = r_winner;
        w_lmode_next  = r_lmode;
        w_mode_next   = r_mode;
        w_ack_next    = '0;
        w_owner_next  = r_owner;
        w_dwell_next  = r_dwell;
        unique case (r_state)
            IDLE: begin
                if (|req) begin
                    w_winner_next = w_winner;
                    w_lmode_next  = w_winner ? light_mode_t'(req_mode1)
                                             : light_mode_t'(req_mode0);
                end
            end
            PEND: begin
                if (req[r_winner] && w_step) begin
                    w_mode_next          = r_lmode;
                    w_ack_next[r_winner] = 1'b1;
                    w_owner_next         = r_winner;
                    w_dwell_next         = DWELL_W'(MIN_DWELL);
                end
            end
            DWELL: begin
                // Guarded so the counter can never wrap below zero.
                if (w_step && (r_dwell != '0)) w_dwell_next = r_dwell - DWELL_W'(1);
            end
            default: begin
                w_dwell_next = '0;
            end
        endcase
        w_busy_next = (w_state_next != IDLE);
    end

    assign ack   = r_ack;
    assign mode  = r_mode;
    assign step  = w_step;
    assign busy  = r_busy;
    assign owner = r_owner;

endmodule

// File: tb/tb_light_mode_scheduler.sv
// Scoreboard bench for light_mode_scheduler with a fast prescaler (DIV_W=2)
// and MIN_DWELL=2. A timeline model predicts grants; a separate monitor
// matches each ack against the expected-grant queue.
module tb_light_mode_scheduler;

    localparam int DIV_W       = 2;
    localparam int MIN_DWELL   = 2;
    localparam int STEP_PERIOD = 1 << DIV_W;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] req = '0;
    logic [1:0] req_mode0 = '0;
    logic [1:0] req_mode1 = '0;
    logic [1:0] ack;
    logic [1:0] mode;
    logic       step;
    logic       busy;
    logic       owner;

    light_mode_scheduler #(
        .DIV_W     (DIV_W),
        .MIN_DWELL (MIN_DWELL),
        .DWELL_W   (8)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .req_mode0 (req_mode0),
        .req_mode1 (req_mode1),
        .ack       (ack),
        .mode      (mode),
        .step      (step),
        .busy      (busy),
        .owner     (owner)
    );

    always #5 clock = ~clock;

    typedef struct {
        int who;
        int mode;
        int cyc;
    } grant_t;

    grant_t exp_q[$];
    int     n_checks = 0;
    int     n_errors = 0;
    int     cyc = 0;
    bit     mon_en = 1'b0;

    // Model: cycles are counted from reset release; steps fall on cyc%4==3.
    int       m_cand;
    int       m_cand_mode;
    int       m_free_from;
    int       m_owner;
    int       m_mode;
    bit       m_busy;
    bit [1:0] m_granted;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    function automatic int pick(input logic [1:0] r);
        if (r == 2'b01) return 0;
        if (r == 2'b10) return 1;
`ifdef LMS_ROUND_ROBIN_EN
        return 1 - m_owner;
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        m_cand      = -1;
        m_cand_mode = 0;
        m_free_from = 0;
        m_owner     = 0;
        m_mode      = 0;
        m_busy      = 1'b0;
        m_granted   = '0;
        exp_q.delete();
        cyc         = 0;
    endtask

    // Advance the model over cycle 'cyc' using the inputs driven for it.
    task automatic model_cycle();
        bit s;
        s = ((cyc % STEP_PERIOD) == STEP_PERIOD - 1);
        m_granted = '0;
        if (m_cand < 0) begin
            if (cyc >= m_free_from && req != 2'b00) begin
                m_cand      = pick(req);
                m_cand_mode = (m_cand == 1) ? int'(req_mode1) : int'(req_mode0);
            end
        end else if (!req[m_cand]) begin
            m_cand = -1;
        end else if (s) begin
            exp_q.push_back('{who: m_cand, mode: m_cand_mode, cyc: cyc + 1});
            m_mode             = m_cand_mode;
            m_owner            = m_cand;
            m_free_from        = cyc + STEP_PERIOD * MIN_DWELL + 1;
            m_granted[m_cand]  = 1'b1;
            m_cand             = -1;
        end
        m_busy = (m_cand >= 0) || (cyc + 1 < m_free_from);
    endtask

    task automatic check_outputs();
        check("step",  step,  ((cyc % STEP_PERIOD) == STEP_PERIOD - 1));
        check("busy",  busy,  m_busy);
        check("mode",  mode,  m_mode);
        check("owner", owner, m_owner);
    endtask

    // Start of a cycle: compare state, then requesters drop a granted request.
    task automatic begin_cycle();
        @(negedge clock);
        cyc++;
        check_outputs();
        for (int i = 0; i < 2; i++) if (m_granted[i]) req[i] = 1'b0;
    endtask

    task automatic end_cycle();
        model_cycle();
    endtask

    task automatic release_reset();
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        check_outputs();
        check("ack_reset", ack, 2'b00);
        mon_en = 1'b1;
        model_cycle();
    endtask

    // Idle until the scheduler is free and the next step is three cycles away.
    task automatic idle_to_boundary();
        for (int k = 0; k < 100; k++) begin
            begin_cycle();
            if (!m_busy && m_cand < 0 && (cyc % STEP_PERIOD) == 0) return;
            end_cycle();
        end
        check("idle_timeout", 0, 1);
        begin_cycle();
    endtask

    task automatic random_drive();
        for (int i = 0; i < 2; i++) begin
            if (!req[i]) begin
                if ($urandom_range(0, 99) < 15) begin
                    req[i] = 1'b1;
                    if (i == 0) req_mode0 = 2'($urandom_range(0, 3));
                    else        req_mode1 = 2'($urandom_range(0, 3));
                end
            end else if ($urandom_range(0, 99) < 3) begin
                req[i] = 1'b0;
            end
        end
    endtask

    task automatic run_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            begin_cycle();
            end_cycle();
        end
    endtask

    // Monitor: every ack must match the oldest expected grant, on time.
    initial begin
        grant_t g;
        forever begin
            @(negedge clock);
            #1;
            if (mon_en) begin
                if (ack != 2'b00) begin
                    if (exp_q.size() == 0) begin
                        check("ack_unexpected", ack, 2'b00);
                    end else begin
                        g = exp_q.pop_front();
                        check("ack_who",   ack,  32'(1) << g.who);
                        check("ack_cycle", cyc,  g.cyc);
                        check("ack_mode",  mode, g.mode);
                    end
                end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                    g = exp_q.pop_front();
                    check("ack_missing", ack, 32'(1) << g.who);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (3) @(negedge clock);
        release_reset();
        run_cycles(12);

        // Single tower request.
        idle_to_boundary();
        req_mode0 = 2'b10;
        req[0]    = 1'b1;
        end_cycle();
        run_cycles(30);

        // Tie between both requesters; the loser stays pending through DWELL.
        idle_to_boundary();
        req_mode0 = 2'b01;
        req_mode1 = 2'b10;
        req       = 2'b11;
        end_cycle();
        run_cycles(40);

        // Winner abandons its request while still in PEND.
        idle_to_boundary();
        req_mode0 = 2'b11;
        req[0]    = 1'b1;
        end_cycle();
        begin_cycle();
        end_cycle();
        begin_cycle();
        req[0] = 1'b0;
        end_cycle();
        run_cycles(10);

        // Randomized traffic.
        for (int k = 0; k < 1500; k++) begin
            begin_cycle();
            random_drive();
            end_cycle();
        end

        // Drain, then reset in the middle of a FREEZE dwell with a request pending.
        begin_cycle();
        req = 2'b00;
        end_cycle();
        run_cycles(30);
        idle_to_boundary();
        req_mode0 = 2'b11;
        req[0]    = 1'b1;
        end_cycle();
        for (int k = 0; k < 20 && !(m_mode == 3 && m_busy && m_cand < 0); k++) begin
            begin_cycle();
            end_cycle();
        end
        begin_cycle();
        req_mode1 = 2'b01;
        req[1]    = 1'b1;
        end_cycle();
        run_cycles(3);
        check("mode_pre_reset", mode, 2'b11);
        #2;
        mon_en = 1'b0;
        reset  = 1'b1;
        #1;
        check("rst_mode",  mode,  2'b00);
        check("rst_busy",  busy,  1'b0);
        check("rst_step",  step,  1'b0);
        check("rst_ack",   ack,   2'b00);
        check("rst_owner", owner, 1'b0);
        repeat (2) @(negedge clock);
        release_reset();
        run_cycles(20);

        begin_cycle();
        req = 2'b00;
        end_cycle();
        run_cycles(30);
        check("queue_drain", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
